// File: rtl/dp_ram_port_arb_pkg.sv
// dp_ram_port_arb_pkg: FSM state encoding and op codes shared by the RAM port arbiter.
package dp_ram_port_arb_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CMD = 2'd1, ST_RDCAP = 2'd2} state_t;
   localparam logic OP_WR = 1'b0;
   localparam logic OP_RD = 1'b1;
endpackage

// File: rtl/dp_ram_port_arb_if.sv
// dp_ram_port_arb_if: requester command/return bus plus the shared RAM port.
interface dp_ram_port_arb_if #(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 2,
   parameter int ADDR_WIDTH = 2
) ();
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ-1:0]            req_wr_n;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]            ack;
   logic [NUM_REQ-1:0]            rd_valid;
   logic [DATA_WIDTH-1:0]         rd_data;
   logic                          ram_we_n;
   logic                          ram_re;
   logic [ADDR_WIDTH-1:0]         ram_addr;
   logic [DATA_WIDTH-1:0]         ram_din;
   logic [DATA_WIDTH-1:0]         ram_dout;
   modport master (
      output req, req_wr_n, req_addr, req_wdata, ram_dout,
      input  ack, rd_valid, rd_data, ram_we_n, ram_re, ram_addr, ram_din
   );
   modport slave (
      input  req, req_wr_n, req_addr, req_wdata, ram_dout,
      output ack, rd_valid, rd_data, ram_we_n, ram_re, ram_addr, ram_din
   );
endinterface

// File: rtl/dp_ram_port_arb_pick.sv
// ram_arb_pick: combinational winner select; ARB_ROUND_ROBIN_EN gives round-robin from ptr,
// otherwise fixed priority with the lowest index winning.
module ram_arb_pick #(
   parameter  int N  = 2,
   localparam int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
`ifdef ARB_ROUND_ROBIN_EN
   input  logic [PW-1:0] ptr,
`endif
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] idx
);
   // Scanning from the far end lets the nearest requester overwrite idx last.
   always_comb begin
      idx = '0;
`ifdef ARB_ROUND_ROBIN_EN
      for (int k = N - 1; k >= 0; k--)
         if (req[(int'(ptr) + k) % N]) idx = PW'((int'(ptr) + k) % N);
`else
      for (int k = N - 1; k >= 0; k--)
         if (req[k]) idx = PW'(k);
`endif
      gnt = '0;
      if (|req) gnt[idx] = 1'b1;
   end
endmodule

// File: rtl/dp_ram_port_arb.sv
// dp_ram_port_arb: serialises NUM_REQ requesters onto one registered-read RAM port.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module dp_ram_port_arb import dp_ram_port_arb_pkg::*; #(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 2,
   parameter int ADDR_WIDTH = 2
) (
   input logic              clk,
   input logic              rst_n,
   dp_ram_port_arb_if.slave bus
);
   localparam int PW = $clog2(NUM_REQ);
   state_t                state;
   logic                  op;
   logic [NUM_REQ-1:0]    gnt, sel, ack, rd_valid;
   logic [PW-1:0]         idx;
   logic [DATA_WIDTH-1:0] rd_data, ram_din;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  ram_we_n, ram_re;
`ifdef ARB_ROUND_ROBIN_EN
   logic [PW-1:0]         ptr;
   ram_arb_pick #(.N(NUM_REQ)) u_pick (.req(bus.req), .ptr(ptr), .gnt(gnt), .idx(idx));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr <= '0;
      else if (state == ST_IDLE && |bus.req) ptr <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
`else
   ram_arb_pick #(.N(NUM_REQ)) u_pick (.req(bus.req), .gnt(gnt), .idx(idx));
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         op       <= OP_WR;
         sel      <= '0;
         ack      <= '0;
         rd_valid <= '0;
         rd_data  <= '0;
         ram_we_n <= 1'b1;
         ram_re   <= 1'b0;
         ram_addr <= '0;
         ram_din  <= '0;
      end else begin
         ack      <= '0;
         rd_valid <= '0;
         case (state)
            ST_IDLE: if (|bus.req) begin
               sel      <= gnt;
               ack      <= gnt;
               op       <= bus.req_wr_n[idx];
               ram_addr <= bus.req_addr[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH];
               ram_din  <= bus.req_wdata[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
               ram_we_n <= bus.req_wr_n[idx];
               ram_re   <= bus.req_wr_n[idx] == OP_RD;
               state    <= ST_CMD;
            end
            ST_CMD: begin
               ram_we_n <= 1'b1;
               ram_re   <= 1'b0;
               state    <= (op == OP_RD) ? ST_RDCAP : ST_IDLE;
            end
            ST_RDCAP: begin
               rd_data  <= bus.ram_dout;
               rd_valid <= sel;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
   assign bus.ack      = ack;
   assign bus.rd_valid = rd_valid;
   assign bus.rd_data  = rd_data;
   assign bus.ram_we_n = ram_we_n;
   assign bus.ram_re   = ram_re;
   assign bus.ram_addr = ram_addr;
   assign bus.ram_din  = ram_din;
endmodule

// File: tb/tb_dp_ram_port_arb.sv
// tb_dp_ram_port_arb: scoreboard bench with a transaction-level arbiter/RAM reference model.
module tb_dp_ram_port_arb;
   localparam int N  = 2;
   localparam int DW = 2;
   localparam int AW = 2;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   typedef struct {int cyc; int w; int a; int d;} ev_t;

   logic clk, rst_n;
   dp_ram_port_arb_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
   dp_ram_port_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   logic          r_req [N];
   logic          r_wr_n[N];
   logic [AW-1:0] r_addr[N];
   logic [DW-1:0] r_wdata[N];
   logic [DW-1:0] mem    [0:3] = '{2'd0, 2'd1, 2'd2, 2'd3};
   logic [DW-1:0] ref_mem[0:3] = '{2'd0, 2'd1, 2'd2, 2'd3};
   ev_t ack_q[$], rd_q[$], we_q[$], re_q[$], glog[$];
   ev_t e;
   int cyc = 0, next_ok = 0, ptr_m = 0, w;
   int asserts = 0, fails = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         bus.req[i]               = r_req[i];
         bus.req_wr_n[i]          = r_wr_n[i];
         bus.req_addr[i*AW +: AW] = r_addr[i];
         bus.req_wdata[i*DW +: DW] = r_wdata[i];
      end
   end

   // RAM port: write commits at the edge, read data registered at the edge
   always @(posedge clk) begin
      if (!rst_n) bus.ram_dout <= '0;
      else if (bus.ram_re) bus.ram_dout <= mem[bus.ram_addr];
      if (!bus.ram_we_n) mem[bus.ram_addr] <= bus.ram_din;
   end

   task automatic chk(input bit ok, input string nm, input int act, input int exp);
      asserts++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         int j = RR ? (p + k) % N : k;
         if (r[j]) return j;
      end
      return 0;
   endfunction

   // Reference model: a grant whenever the port is free, write busy 2 cycles, read busy 3
   always @(posedge clk) begin
      if (!rst_n) begin
         next_ok = cyc + 1;
         ptr_m   = 0;
      end else if (cyc >= next_ok && |bus.req) begin
         w = pick(bus.req, ptr_m);
         ack_q.push_back('{cyc + 1, w, 0, 0});
         if (r_wr_n[w] == 1'b0) begin
            ref_mem[r_addr[w]] = r_wdata[w];
            we_q.push_back('{cyc + 1, w, int'(r_addr[w]), int'(r_wdata[w])});
            next_ok = cyc + 2;
         end else begin
            re_q.push_back('{cyc + 1, w, int'(r_addr[w]), 0});
            rd_q.push_back('{cyc + 3, w, 0, int'(ref_mem[r_addr[w]])});
            next_ok = cyc + 3;
         end
         ptr_m = (w + 1) % N;
      end
      cyc = cyc + 1;
   end

   // Monitor
   always @(negedge clk) begin
      if (!rst_n) begin
         chk(bus.ack == 0 && bus.rd_valid == 0 && bus.rd_data == 0 && bus.ram_we_n && !bus.ram_re &&
             bus.ram_addr == 0 && bus.ram_din == 0, "reset_vals", int'(bus.ack), 0);
      end else begin
         if (bus.ack != 0) begin
            for (int i = 0; i < N; i++) if (bus.ack[i]) glog.push_back('{cyc, i, 0, 0});
            if (ack_q.size() == 0) chk(1'b0, "ack_unexpected", int'(bus.ack), 0);
            else begin
               e = ack_q.pop_front();
               chk(int'(bus.ack) == (1 << e.w), "ack_vec", int'(bus.ack), 1 << e.w);
               chk(e.cyc == cyc, "ack_cycle", cyc, e.cyc);
            end
         end
         if (bus.rd_valid != 0) begin
            chk((bus.ack & bus.rd_valid) == 0, "ack_rdv_overlap", int'(bus.ack & bus.rd_valid), 0);
            if (rd_q.size() == 0) chk(1'b0, "rdv_unexpected", int'(bus.rd_valid), 0);
            else begin
               e = rd_q.pop_front();
               chk(int'(bus.rd_valid) == (1 << e.w), "rdv_vec", int'(bus.rd_valid), 1 << e.w);
               chk(e.cyc == cyc, "rdv_cycle", cyc, e.cyc);
               chk(int'(bus.rd_data) == e.d, "rd_data", int'(bus.rd_data), e.d);
            end
         end
         if (!bus.ram_we_n) begin
            if (we_q.size() == 0) chk(1'b0, "we_unexpected", 0, 1);
            else begin
               e = we_q.pop_front();
               chk(e.cyc == cyc && int'(bus.ram_addr) == e.a, "we_addr", int'(bus.ram_addr), e.a);
               chk(int'(bus.ram_din) == e.d, "we_data", int'(bus.ram_din), e.d);
            end
         end
         if (bus.ram_re) begin
            if (re_q.size() == 0) chk(1'b0, "re_unexpected", 1, 0);
            else begin
               e = re_q.pop_front();
               chk(e.cyc == cyc && int'(bus.ram_addr) == e.a, "re_addr", int'(bus.ram_addr), e.a);
            end
         end
         if (ack_q.size() && ack_q[0].cyc < cyc) begin chk(1'b0, "ack_missing", 0, ack_q[0].cyc); ack_q.delete(0); end
         if (rd_q.size() && rd_q[0].cyc < cyc) begin chk(1'b0, "rdv_missing", 0, rd_q[0].cyc); rd_q.delete(0); end
         if (we_q.size() && we_q[0].cyc < cyc) begin chk(1'b0, "we_missing", 0, we_q[0].cyc); we_q.delete(0); end
         if (re_q.size() && re_q[0].cyc < cyc) begin chk(1'b0, "re_missing", 0, re_q[0].cyc); re_q.delete(0); end
      end
   end

   task automatic issue(input int i, input bit wr_n, input int addr, input int data);
      bit got = 1'b0;
      r_req[i] = 1'b1; r_wr_n[i] = wr_n; r_addr[i] = AW'(addr); r_wdata[i] = DW'(data);
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         got = bus.ack[i];
      end
      r_req[i] = 1'b0;
      chk(got, "ack_timeout", int'(got), 1);
   endtask

   task automatic hold(input int i, input bit wr_n, input int addr, input int n);
      r_req[i] = 1'b1; r_wr_n[i] = wr_n; r_addr[i] = AW'(addr); r_wdata[i] = '0;
      repeat (n) @(negedge clk);
      r_req[i] = 1'b0;
   endtask

   initial begin
      int exp4;
      for (int i = 0; i < N; i++) begin
         r_req[i] = 1'b0; r_wr_n[i] = 1'b1; r_addr[i] = '0; r_wdata[i] = '0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      // idle after reset
      repeat (10) begin
         @(negedge clk);
         chk(bus.ram_we_n && !bus.ram_re && bus.ack == 0 && bus.rd_valid == 0, "idle", int'(bus.ram_re), 0);
      end
      chk(bus.rd_data == 0 && bus.ram_addr == 0, "idle_data", int'(bus.rd_data), 0);
      // both requesters hold reads
      glog.delete();
      fork hold(0, 1'b1, 1, 11); hold(1, 1'b1, 2, 11); join
      repeat (6) @(negedge clk);
      chk(glog.size() == 4, "t3_grant_count", glog.size(), 4);
      for (int k = 0; k < 4 && k < glog.size(); k++)
         chk(glog[k].w == (RR ? k % 2 : 0), "t3_grant", glog[k].w, RR ? k % 2 : 0);
      // write then read back
      issue(0, 1'b0, 2, 3);
      issue(0, 1'b1, 2, 0);
      repeat (5) @(negedge clk);
      chk(bus.rd_data == 3, "t2_rdata", int'(bus.rd_data), 3);
      // simultaneous write and read of addr 0
      exp4 = RR ? 2 : int'(ref_mem[0]);
      fork issue(1, 1'b0, 0, 2); issue(0, 1'b1, 0, 0); join
      repeat (6) @(negedge clk);
      chk(int'(bus.rd_data) == exp4, "t4_rdata", int'(bus.rd_data), exp4);
      // reset while read data is being captured
      issue(0, 1'b1, 1, 0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      ack_q.delete(); rd_q.delete(); we_q.delete(); re_q.delete();
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk(bus.rd_data == 0, "t5_no_capture", int'(bus.rd_data), 0);
      issue(1, 1'b1, 2, 0);
      repeat (5) @(negedge clk);
      chk(bus.rd_data == ref_mem[2], "t5_rdata", int'(bus.rd_data), int'(ref_mem[2]));
      // back-to-back reads
      glog.delete();
      hold(0, 1'b1, 3, 13);
      repeat (6) @(negedge clk);
      chk(glog.size() == 5, "t6_count", glog.size(), 5);
      for (int k = 0; k + 1 < glog.size(); k++)
         chk(glog[k+1].cyc - glog[k].cyc == 3, "t6_spacing", glog[k+1].cyc - glog[k].cyc, 3);
      // random traffic from both requesters
      fork
         for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         end
         for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         end
      join
      repeat (10) @(negedge clk);
      chk(ack_q.size() + rd_q.size() + we_q.size() + re_q.size() == 0, "drain",
          ack_q.size() + rd_q.size() + we_q.size() + re_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
      $fatal(1, "timeout");
   end
endmodule
